vga_timing_pipe: RTL

- Parametrised successor to the team's 640x480 VGA driver.
- Generates programmable H/V timing with configurable sync polarity, and runs from a pixel clock-enable so it can sit on a faster system clock.
- Issues row/column requests to a pixel generator with a fixed pipeline latency. Sync and blanking are delayed by that latency plus one, so they stay aligned with returned pixels.
- Adds an internal colour-bar test pattern and frame/line strobes for game logic.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay_line.sv | 47 ++++
 rtl/vga_timing_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and colour-bar helper
package vga_pkg;

  // 640x480@60 timing (25.175 MHz pixel clock)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_RGB_WIDTH   = 3;
  localparam int DEF_COUNT_WIDTH = 10;
  localparam int DEF_PIX_LATENCY = 2;

  // Bar index 0..7 -> {R,G,B}; inverting the index gives
  // white, yellow, magenta, red, cyan, green, blue, black across the line.
  function automatic logic [2:0] colour_bar(input logic [2:0] bar);
    return ~bar;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with async clear
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero depth: the consumer samples the input directly.
      logic unused_ok;
      assign unused_ok = &{1'b0, clock, reset, en};
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      // Shift one stage per enabled tick, hold otherwise.
      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d[0] = din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
      end

      // Stage registers; clearing to zero means "inactive" for the sideband.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - parametrised VGA timing with pixel-request pipeline
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int RGB_WIDTH   = DEF_RGB_WIDTH,
  parameter int PIX_LATENCY = DEF_PIX_LATENCY,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic                   test_pattern,
  output logic [COUNT_WIDTH-1:0] pixel_row,
  output logic [COUNT_WIDTH-1:0] pixel_col,
  output logic                   pixel_req,
  input  logic [RGB_WIDTH-1:0]   pixel_rgb,
  output logic                   frame_start,
  output logic                   line_start,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [RGB_WIDTH-1:0]   vga_rgb,
  output logic                   vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CH_W    = RGB_WIDTH / 3;
  localparam int SB_W    = 7;

  localparam logic [COUNT_WIDTH-1:0] H_LAST    = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST    = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] H_ACT_C   = COUNT_WIDTH'(H_ACTIVE);
  localparam logic [COUNT_WIDTH-1:0] V_ACT_C   = COUNT_WIDTH'(V_ACTIVE);
  localparam logic [COUNT_WIDTH-1:0] H_SYNC_LO = COUNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COUNT_WIDTH-1:0] H_SYNC_HI = COUNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_WIDTH-1:0] V_SYNC_LO = COUNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNT_WIDTH-1:0] V_SYNC_HI = COUNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COUNT_WIDTH-1:0] BAR_DIV   = COUNT_WIDTH'(H_ACTIVE / 8);
  localparam logic [COUNT_WIDTH-1:0] BAR_MAX   = COUNT_WIDTH'(7);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  generate
    if (RGB_WIDTH % 3 != 0) begin : g_bad_rgb
      $error("vga_timing_pipe: RGB_WIDTH must be a multiple of 3");
    end
    if (H_ACTIVE < 8) begin : g_bad_hact
      $error("vga_timing_pipe: H_ACTIVE must be at least 8");
    end
    if (H_TOTAL > 2**COUNT_WIDTH || V_TOTAL > 2**COUNT_WIDTH) begin : g_bad_cw
      $error("vga_timing_pipe: COUNT_WIDTH too small for the frame totals");
    end
    if (PIX_LATENCY < 0 || PIX_LATENCY > 8) begin : g_bad_lat
      $error("vga_timing_pipe: PIX_LATENCY must be 0..8");
    end
  endgenerate

  logic [COUNT_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic                   frame_start_q, frame_start_d;
  logic                   line_start_q, line_start_d;
  logic [RGB_WIDTH-1:0]   rgb_q, rgb_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   vblank_q, vblank_d;

  logic                   active, hs_raw, vs_raw, vb_raw;
  logic [COUNT_WIDTH-1:0] bar_idx;
  logic [2:0]             bar_colour;

  logic [SB_W-1:0]        sb_in, sb_out;
  logic                   dl_active, dl_hs, dl_vs, dl_vb;
  logic [2:0]             dl_colour;
  logic [RGB_WIDTH-1:0]   bar_rgb;

  // Raster counters plus the undelayed line/frame strobes that track them.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
      end else begin
        h_d = h_q + ONE;
      end
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  // Stage-0 decode of the current counter position.
  always_comb begin
    active     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs_raw     = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
    vs_raw     = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);
    vb_raw     = (v_q >= V_ACT_C);
    bar_idx    = h_q / BAR_DIV;
    bar_colour = colour_bar((bar_idx > BAR_MAX) ? 3'd7 : bar_idx[2:0]);
  end

  assign sb_in = {active, hs_raw, vs_raw, vb_raw, bar_colour};

  vga_delay_line #(
    .WIDTH (SB_W),
    .DEPTH (PIX_LATENCY)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .en    (pix_en),
    .din   (sb_in),
    .dout  (sb_out)
  );

  assign {dl_active, dl_hs, dl_vs, dl_vb, dl_colour} = sb_out;
  assign bar_rgb = {{CH_W{dl_colour[2]}}, {CH_W{dl_colour[1]}}, {CH_W{dl_colour[0]}}};

  // Output register inputs: blank the colour outside the active area.
  always_comb begin
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    vblank_d = vblank_q;
    if (pix_en) begin
      rgb_d    = dl_active ? (test_pattern ? bar_rgb : pixel_rgb) : '0;
      hsync_d  = dl_hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = dl_vs ? VSYNC_POL : ~VSYNC_POL;
      vblank_d = dl_vb;
    end
  end

  // All state registers; reset parks syncs at their idle level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      vblank_q      <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
    end
  end

  assign pixel_row   = v_q;
  assign pixel_col   = h_q;
  assign pixel_req   = active;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_rgb     = rgb_q;
  assign vblank      = vblank_q;

endmodule
